// File: rtl/us_frame_wr.sv
// Record writer: frames header, packed data, trailer and checksum into one bank of a
// ping-pong dual-port buffer, with bank flip on every frame sync.
module us_frame_wr #(
    parameter int HDR_WORDS = 5,
    parameter int ADDR_W    = 10,
    parameter int LEN_W     = 11,
    parameter int CH_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_sync,
    input  logic                      i_sub_sync,
    input  logic [CH_W-1:0]           i_sub_channel,
    input  logic [32*HDR_WORDS-1:0]   i_hdr,
    input  logic [LEN_W-1:0]          i_scan_len,
    input  logic [31:0]               i_in_data,
    input  logic                      i_in_vld,
    output logic [ADDR_W:0]           o_wr_addr,
    output logic [31:0]               o_wr_data,
    output logic                      o_wr_en,
    output logic                      o_bank,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_ovf
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_TRL0 = 3'd3,
        ST_TRL1 = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [3:0]              hdr_idx_r;
    logic [32*HDR_WORDS-1:0] hdr_r;
    logic [CH_W-1:0]         ch_r;
    logic [LEN_W-1:0]        len_r, cnt_r, cnt_inc_s;
    logic [31:0]             sum_r;
    logic [7:0]              seq_r;
    logic [ADDR_W-1:0]       ptr_r;
    logic                    bank_r, ovf_r, done_r, busy_r, wr_en_r;
    logic [ADDR_W:0]         wr_addr_r;
    logic [31:0]             wr_data_r;
    logic                    wr_req_s, drop_s, full_s, wr_go_s;
    logic [31:0]             word_s;

    function automatic logic [31:0] trailer_word(input logic ovf, input logic [CH_W-1:0] ch,
                                                 input logic [7:0] seq, input logic [LEN_W-1:0] cnt);
        return {ovf, 7'(ch), seq, 16'(cnt)};
    endfunction

    assign cnt_inc_s = cnt_r + LEN_W'(1);
    // The last buffer word is never written: reaching it marks the bank full.
    assign full_s    = (ptr_r == {ADDR_W{1'b1}});
    assign wr_go_s   = wr_req_s & ~full_s;

    // State register and busy flag aligned with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Next-state logic; a record start overrides everything, a frame sync aborts.
    always_comb begin
        state_s = state_r;
        if (i_sub_sync) begin
            state_s = ST_HDR;
        end else if (i_sync) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_IDLE;
                ST_HDR: begin
                    if (hdr_idx_r == 4'(HDR_WORDS - 1)) begin
                        state_s = (len_r == '0) ? ST_TRL0 : ST_DATA;
                    end else begin
                        state_s = ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (i_in_vld && (cnt_inc_s == len_r)) begin
                        state_s = ST_TRL0;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_TRL0: state_s = ST_TRL1;
                ST_TRL1: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode: which word (if any) goes to the buffer this cycle.
    always_comb begin
        wr_req_s = 1'b0;
        drop_s   = 1'b0;
        word_s   = 32'd0;
        if (i_sync || i_sub_sync) begin
            wr_req_s = 1'b0;
        end else begin
            case (state_r)
                ST_HDR: begin
                    wr_req_s = 1'b1;
                    word_s   = hdr_r[32*HDR_WORDS-1 -: 32];
                    drop_s   = i_in_vld;
                end
                ST_DATA: begin
                    wr_req_s = i_in_vld;
                    word_s   = i_in_data;
                end
                ST_TRL0: begin
                    wr_req_s = 1'b1;
                    // seq was already advanced on entry, so the record's own number is one back
                    word_s   = trailer_word(ovf_r, ch_r, seq_r - 8'd1, cnt_r);
                end
                ST_TRL1: begin
                    wr_req_s = 1'b1;
                    word_s   = sum_r;
                end
                default: begin
                    wr_req_s = 1'b0;
                end
            endcase
        end
    end

    // Frame-level state: pointer, bank, overrun flag and record sequence number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r  <= '0;
            bank_r <= 1'b0;
            ovf_r  <= 1'b0;
            seq_r  <= 8'd0;
        end else if (i_sync) begin
            ptr_r  <= '0;
            bank_r <= ~bank_r;
            ovf_r  <= 1'b0;
            seq_r  <= 8'd0;
        end else begin
            if (wr_go_s) begin
                ptr_r <= ptr_r + ADDR_W'(1);
            end
            if ((wr_req_s && full_s) || drop_s) begin
                ovf_r <= 1'b1;
            end
            if ((state_s == ST_TRL0) && (state_r != ST_TRL0)) begin
                seq_r <= seq_r + 8'd1;
            end
        end
    end

    // Per-record context latched on the record start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_r      <= '0;
            hdr_r     <= '0;
            len_r     <= '0;
            cnt_r     <= '0;
            sum_r     <= 32'd0;
            hdr_idx_r <= 4'd0;
            done_r    <= 1'b1;
        end else if (i_sub_sync) begin
            ch_r      <= i_sub_channel;
            hdr_r     <= i_hdr;
            len_r     <= i_scan_len;
            cnt_r     <= '0;
            sum_r     <= 32'd0;
            hdr_idx_r <= 4'd0;
            done_r    <= 1'b0;
        end else begin
            if (state_r == ST_HDR) begin
                hdr_idx_r <= hdr_idx_r + 4'd1;
                hdr_r     <= hdr_r << 6'd32;
            end
            if ((state_r == ST_DATA) && i_in_vld) begin
                cnt_r <= cnt_inc_s;
                sum_r <= sum_r + i_in_data;
            end
            if ((state_r == ST_TRL1) && !i_sync) begin
                done_r <= 1'b1;
            end
        end
    end

    // Registered buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 32'd0;
        end else begin
            wr_en_r <= wr_go_s;
            if (wr_go_s) begin
                wr_addr_r <= {bank_r, ptr_r};
                wr_data_r <= word_s;
            end
        end
    end

    assign o_wr_en   = wr_en_r;
    assign o_wr_addr = wr_addr_r;
    assign o_wr_data = wr_data_r;
    assign o_bank    = bank_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_ovf     = ovf_r;

endmodule

// File: tb/tb_us_frame_wr.sv
// Bench for us_frame_wr: directed record scenarios plus random traffic, two instances
// (full-size and 16-word banks) checked against a word-stream reference model.
module tb_us_frame_wr;

    localparam int HDR = 5;

    logic              clk, rst_n;
    logic              i_sync, i_sub_sync, i_in_vld;
    logic [2:0]        i_sub_channel;
    logic [32*HDR-1:0] i_hdr;
    logic [10:0]       i_scan_len;
    logic [31:0]       i_in_data;
    logic [10:0]       o_wr_addr0;
    logic [4:0]        o_wr_addr1;
    logic [31:0]       o_wr_data0, o_wr_data1;
    logic              o_wr_en0, o_bank0, o_busy0, o_done0, o_ovf0;
    logic              o_wr_en1, o_bank1, o_busy1, o_done1, o_ovf1;

    us_frame_wr u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_sub_sync(i_sub_sync),
        .i_sub_channel(i_sub_channel), .i_hdr(i_hdr), .i_scan_len(i_scan_len),
        .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_wr_addr(o_wr_addr0),
        .o_wr_data(o_wr_data0), .o_wr_en(o_wr_en0), .o_bank(o_bank0),
        .o_busy(o_busy0), .o_done(o_done0), .o_ovf(o_ovf0)
    );

    us_frame_wr #(.ADDR_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_sub_sync(i_sub_sync),
        .i_sub_channel(i_sub_channel), .i_hdr(i_hdr), .i_scan_len(i_scan_len),
        .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_wr_addr(o_wr_addr1),
        .o_wr_data(o_wr_data1), .o_wr_en(o_wr_en1), .o_bank(o_bank1),
        .o_busy(o_busy1), .o_done(o_done1), .o_ovf(o_ovf1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mem0 [2048];

    // Reference model: record as a stream of words, per-instance pointer and overrun.
    int          m_bank, m_seq, m_trl_seq, m_ch, m_len, m_cnt, m_hdr_left, m_trl_left;
    logic [31:0] m_sum;
    logic [32*HDR-1:0] m_hdr;
    bit          m_active, m_done;
    int          m_ptr [2];
    bit          m_ovf [2];
    bit          e_en  [2];
    int          e_addr[2];
    logic [31:0] e_data[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int aw(input int i);
        return (i == 0) ? 10 : 4;
    endfunction

    task automatic model_reset();
        m_bank = 0; m_seq = 0; m_active = 0; m_done = 1;
        m_hdr_left = 0; m_trl_left = 0;
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0; m_ovf[i] = 0; e_en[i] = 0;
        end
    endtask

    task automatic emit(input int i, input logic [31:0] w);
        if (m_ptr[i] == (1 << aw(i)) - 1) begin
            m_ovf[i] = 1;
        end else begin
            e_en[i]   = 1;
            e_addr[i] = (m_bank << aw(i)) + m_ptr[i];
            e_data[i] = w;
            m_ptr[i]++;
        end
    endtask

    task automatic close_record();
        m_trl_seq  = m_seq;
        m_seq      = (m_seq + 1) % 256;
        m_trl_left = 2;
    endtask

    task automatic model_step(input logic s, input logic ss, input logic v, input logic [31:0] d);
        logic [31:0] tw;
        for (int i = 0; i < 2; i++) e_en[i] = 0;
        if (s) begin
            m_bank = 1 - m_bank; m_seq = 0; m_active = 0;
            for (int i = 0; i < 2; i++) begin m_ptr[i] = 0; m_ovf[i] = 0; end
        end
        if (ss) begin
            m_ch = int'(i_sub_channel); m_len = int'(i_scan_len); m_hdr = i_hdr;
            m_cnt = 0; m_sum = 32'd0; m_hdr_left = HDR; m_trl_left = 0;
            m_active = 1; m_done = 0;
        end else if (m_active) begin
            if (m_hdr_left > 0) begin
                for (int i = 0; i < 2; i++) begin
                    emit(i, m_hdr[32*(m_hdr_left-1) +: 32]);
                    if (v) m_ovf[i] = 1;
                end
                m_hdr_left--;
                if (m_hdr_left == 0 && m_len == 0) close_record();
            end else if (m_trl_left == 2) begin
                for (int i = 0; i < 2; i++) begin
                    tw = (m_ovf[i] ? 32'h8000_0000 : 32'h0) + 32'(m_ch * (1 << 24))
                       + 32'(m_trl_seq * 65536) + 32'(m_cnt % 65536);
                    emit(i, tw);
                end
                m_trl_left = 1;
            end else if (m_trl_left == 1) begin
                for (int i = 0; i < 2; i++) emit(i, m_sum);
                m_trl_left = 0; m_active = 0; m_done = 1;
            end else if (v) begin
                for (int i = 0; i < 2; i++) emit(i, d);
                m_sum = m_sum + d;
                m_cnt++;
                if (m_cnt == m_len) close_record();
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("wr_en0", 32'(o_wr_en0), 32'(e_en[0]));
        check_eq("wr_en1", 32'(o_wr_en1), 32'(e_en[1]));
        if (e_en[0]) begin
            check_eq("wr_addr0", 32'(o_wr_addr0), 32'(e_addr[0]));
            check_eq("wr_data0", o_wr_data0, e_data[0]);
        end
        if (e_en[1]) begin
            check_eq("wr_addr1", 32'(o_wr_addr1), 32'(e_addr[1]));
            check_eq("wr_data1", o_wr_data1, e_data[1]);
        end
        if (o_wr_en0) mem0[o_wr_addr0] = o_wr_data0;
        check_eq("ovf0",  32'(o_ovf0),  32'(m_ovf[0]));
        check_eq("ovf1",  32'(o_ovf1),  32'(m_ovf[1]));
        check_eq("bank0", 32'(o_bank0), 32'(m_bank));
        check_eq("bank1", 32'(o_bank1), 32'(m_bank));
        check_eq("busy0", 32'(o_busy0), 32'(m_active));
        check_eq("busy1", 32'(o_busy1), 32'(m_active));
        check_eq("done0", 32'(o_done0), 32'(m_done));
        check_eq("done1", 32'(o_done1), 32'(m_done));
    endtask

    // One clock: drive at the falling edge, predict, check at the next falling edge.
    task automatic cyc(input logic s, input logic ss, input logic v, input logic [31:0] d);
        i_sync = s; i_sub_sync = ss; i_in_vld = v; i_in_data = d;
        if (rst_n) model_step(s, ss, v, d);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic set_rec(input int ch, input int len);
        i_sub_channel = 3'(ch);
        i_scan_len    = 11'(len);
        i_hdr         = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_wr_en"},   32'(o_wr_en0),  32'd0);
        check_eq({tag, "_wr_data"}, o_wr_data0,     32'd0);
        check_eq({tag, "_busy"},    32'(o_busy0),   32'd0);
        check_eq({tag, "_ovf"},     32'(o_ovf0),    32'd0);
        check_eq({tag, "_done"},    32'(o_done0),   32'd1);
        check_eq({tag, "_bank"},    32'(o_bank0),   32'd0);
        check_eq({tag, "_bank1"},   32'(o_bank1),   32'd0);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        i_sync = 1'b0; i_sub_sync = 1'b0; i_in_vld = 1'b0; i_in_data = 32'd0;
        i_sub_channel = 3'd0; i_scan_len = 11'd0; i_hdr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Basic record in the freshly toggled bank
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        set_rec(2, 3);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        idle(HDR);
        for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b0, 1'b1, 32'(k));
        idle(3);
        check_eq("rec1_hdr0",    mem0[11'h400], i_hdr[32*HDR-1 -: 32]);
        check_eq("rec1_data2",   mem0[11'h407], 32'd3);
        check_eq("rec1_trailer", mem0[11'h408], 32'h0200_0003);
        check_eq("rec1_sum",     mem0[11'h409], 32'd6);
        check_eq("rec1_done",    32'(o_done0), 32'd1);

        // Second record in the same frame continues the pointer and sequence
        set_rec(5, 2);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        idle(HDR);
        cyc(1'b0, 1'b0, 1'b1, 32'd10);
        cyc(1'b0, 1'b0, 1'b1, 32'd20);
        idle(3);
        check_eq("rec2_trailer", mem0[11'h411], 32'h0501_0002);
        check_eq("rec2_sum",     mem0[11'h412], 32'd30);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        check_eq("sync_bank", 32'(o_bank0), 32'd0);

        // Data arriving during the header is dropped and flagged
        set_rec(1, 2);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        idle(HDR - 2);
        cyc(1'b0, 1'b0, 1'b1, 32'd7);
        cyc(1'b0, 1'b0, 1'b1, 32'd8);
        idle(3);
        check_eq("hdr_drop_trl_bit31", 32'(mem0[11'd7] >> 31), 32'd1);
        check_eq("hdr_drop_sum",       mem0[11'd8], 32'd15);

        // Long record overflows the 16-word instance
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        set_rec(3, 20);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        idle(HDR);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b1, $urandom());
        idle(3);
        check_eq("small_ovf",  32'(o_ovf1), 32'd1);
        check_eq("large_ovf",  32'(o_ovf0), 32'd0);

        // Restart mid-data abandons the record without a trailer
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        set_rec(4, 6);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        idle(HDR);
        cyc(1'b0, 1'b0, 1'b1, 32'd100);
        cyc(1'b0, 1'b0, 1'b1, 32'd200);
        set_rec(6, 1);
        cyc(1'b0, 1'b1, 1'b1, 32'd300);
        idle(HDR);
        cyc(1'b0, 1'b0, 1'b1, 32'd400);
        idle(3);

        // Sync and record start together, then reset mid-data
        set_rec(7, 4);
        cyc(1'b1, 1'b1, 1'b0, 32'd0);
        idle(HDR);
        cyc(1'b0, 1'b0, 1'b1, 32'd5);
        cyc(1'b0, 1'b0, 1'b1, 32'd6);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic s, ss;
            s  = ($urandom_range(0, 99) == 0);
            ss = ($urandom_range(0, 39) == 0);
            if (ss) set_rec(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
            cyc(s, ss, 1'($urandom_range(0, 9) < 6), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/us_frame_wr.md
US_FRAME_WR -- requirements
Module: us_frame_wr

Interface
REQ-001 Parameter HDR_WORDS, default 5: header words written at start of each record (1..15).
REQ-002 Parameter ADDR_W, default 10: word address width of one buffer bank.
REQ-003 Parameter LEN_W, default 11: width of scan length.
REQ-004 Parameter CH_W, default 3: sub-channel index width (1..7).
REQ-005 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port i_sync, input, 1: frame start pulse.
REQ-008 Port i_sub_sync, input, 1: record start pulse.
REQ-009 Port i_sub_channel, input, CH_W: channel tag, sampled on i_sub_sync.
REQ-010 Port i_hdr, input, 32*HDR_WORDS: header words, most significant word first; sampled on i_sub_sync.
REQ-011 Port i_scan_len, input, LEN_W: data words per record; sampled on i_sub_sync.
REQ-012 Port i_in_data / i_in_vld, input, 32 / 1: upstream packed sample stream; no backpressure.
REQ-013 Port o_wr_addr, output, ADDR_W+1: {bank, word pointer} to the dual-port buffer.
REQ-014 Port o_wr_data / o_wr_en, output, 32 / 1: write word and strobe.
REQ-015 Port o_bank, o_busy, o_done, o_ovf, output, 1 each: current bank, record in progress, record complete, sticky overrun.

Function
REQ-016 The block SHALL use states IDLE, HDR, DATA, TRL0, TRL1.
REQ-017 i_sub_sync in any state SHALL latch the sampled inputs, clear the record word count, clear the checksum, and enter HDR on the next cycle; an unfinished record SHALL be abandoned without a trailer.
REQ-018 HDR SHALL write one header word per cycle, HDR_WORDS cycles, then enter DATA.
REQ-019 An i_in_vld during HDR SHALL be dropped and SHALL set o_ovf.
REQ-020 In DATA, each i_in_vld SHALL write i_in_data in the same cycle (registered write outputs, latency 1), add it to a 32-bit wrap-around checksum, and increment the count.
REQ-021 DATA SHALL go to TRL0 after the write that makes count equal i_scan_len; i_scan_len = 0 SHALL go directly from HDR to TRL0.
REQ-022 TRL0 SHALL write {o_ovf, CH_W channel zero-extended to 7 bits, seq[7:0], count[15:0]}; TRL1 SHALL write the checksum, then go to IDLE with o_done = 1.
REQ-023 seq SHALL be an 8-bit per-frame record counter, wrapping 255 -> 0, incremented on entering TRL0, cleared by i_sync.
REQ-024 The word pointer SHALL increment on every write; at 2^ADDR_W - 1 it SHALL hold, further writes SHALL be suppressed, and o_ovf SHALL set.
REQ-025 i_sync SHALL zero the pointer, toggle o_bank, clear o_ovf and seq, and force IDLE; i_sync and i_sub_sync in the same cycle SHALL apply i_sync first, then start the record in the new bank at pointer 0.
REQ-026 o_busy SHALL be 1 in HDR, DATA, TRL0 and TRL1; o_done SHALL clear on i_sub_sync.
REQ-027 o_wr_en SHALL never assert in IDLE.

Reset
REQ-028 While rst_n = 0: state IDLE, pointer 0, o_bank 0, seq 0, checksum 0, o_wr_en 0, o_wr_data 0, o_busy 0, o_ovf 0, o_done 1; reset SHALL abort any record mid-operation.

Verification
REQ-029 Reset, i_sync, i_sub_sync with ch 2, len 3, data 1,2,3 -> addresses 0x400..0x409 written: 5 header words, data 1,2,3, trailer {0,2,0,3}, checksum 6; o_done = 1.
REQ-030 Two records in one frame -> second trailer seq = 1, pointer continues at 10; next i_sync -> bank 0, pointer 0.
REQ-031 i_in_vld asserted during HDR -> word not written, o_ovf = 1, trailer bit 31 = 1.
REQ-032 ADDR_W = 4, len 20 -> pointer holds at 15, writes stop, o_ovf = 1.
REQ-033 i_sub_sync mid-DATA -> no trailer for the abandoned record, new header written from the current pointer.
REQ-034 i_sync and i_sub_sync in the same cycle, and rst_n pulsed mid-DATA -> bank toggles and the record starts at pointer 0; reset returns to the REQ-028 values immediately.
